// File: rtl/vga_fb_arb.sv
// Framebuffer arbiter: display reads own the single-port SRAM during active video,
// and the host gets the port in blanking. Pixel data and syncs leave through a 2-stage pipeline.
module vga_fb_arb #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int H_SIZE    = 10,
  parameter int V_SIZE    = 10,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 12
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic [H_SIZE-1:0] vga_hc,
  input  logic [V_SIZE-1:0] vga_vc,
  input  logic              vga_hsync_in,
  input  logic              vga_vsync_in,
  input  logic              vga_on_in,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] vga_rgb,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_on,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(H_DISPLAY * V_DISPLAY - 1);
  localparam logic [V_SIZE-1:0] V_LIMIT = V_SIZE'(V_DISPLAY);

  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST_RD} tag_t;

  tag_t              tag_p1, tag_nxt;
  logic              hsync_p1, vsync_p1, on_p1, first_p1;
  logic [ADDR_W-1:0] fb_addr;
  logic              host_xfer;

  // The address counter stops at the last pixel instead of wrapping inside a frame.
  function automatic logic [ADDR_W-1:0] fb_next(input logic [ADDR_W-1:0] a);
    return (a == FB_LAST) ? a : a + 1'b1;
  endfunction

  assign host_ready = ~vga_on_in & ~reset;
  assign host_xfer  = host_valid & host_ready;

  always_comb begin
    mem_addr  = fb_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (host_xfer) begin
      mem_addr  = host_addr;
      mem_we    = host_we;
      mem_wdata = host_wdata;
    end
  end

  always_comb begin
    tag_nxt = TAG_NONE;
    if (vga_on_in)
      tag_nxt = TAG_DISP;
    else if (host_xfer && !host_we)
      tag_nxt = TAG_HOST_RD;
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset)
      fb_addr <= '0;
    else if (vga_vc >= V_LIMIT)
      fb_addr <= '0;
    else if (vga_on_in)
      fb_addr <= fb_next(fb_addr);
  end

  // Stage p1: SRAM read in flight; source tag and syncs travel with it.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      tag_p1   <= TAG_NONE;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      on_p1    <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      tag_p1   <= tag_nxt;
      hsync_p1 <= vga_hsync_in;
      vsync_p1 <= vga_vsync_in;
      on_p1    <= vga_on_in;
      first_p1 <= vga_on_in && (vga_hc == '0) && (vga_vc == '0);
    end
  end

  // Stage p2: SRAM data captured and steered to the display or the host.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vga_rgb     <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_on      <= 1'b0;
      frame_start <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      vga_rgb     <= (tag_p1 == TAG_DISP) ? mem_rdata : '0;
      vga_hsync   <= hsync_p1;
      vga_vsync   <= vsync_p1;
      vga_on      <= on_p1;
      frame_start <= first_p1 & ~vga_on;
      host_rvalid <= (tag_p1 == TAG_HOST_RD);
      if (tag_p1 == TAG_HOST_RD)
        host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vga_fb_arb.sv
// Bench for vga_fb_arb on a reduced raster: random host traffic in blanking,
// directed resets, outputs compared against a frame-level reference model.
module tb_vga_fb_arb;

  localparam int H_DISP = 40;
  localparam int V_DISP = 12;
  localparam int H_TOT  = 50;
  localparam int V_TOT  = 16;
  localparam int AW     = 10;
  localparam int DW     = 12;

  logic          clk, reset;
  logic [9:0]    vga_hc, vga_vc;
  logic          vga_hsync_in, vga_vsync_in, vga_on_in;
  logic          host_valid, host_ready, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] vga_rgb;
  logic          vga_hsync, vga_vsync, vga_on, frame_start;

  vga_fb_arb #(
    .H_DISPLAY(H_DISP), .V_DISPLAY(V_DISP), .H_SIZE(10), .V_SIZE(10),
    .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .pixel_clk(clk), .reset(reset),
    .vga_hc(vga_hc), .vga_vc(vga_vc),
    .vga_hsync_in(vga_hsync_in), .vga_vsync_in(vga_vsync_in), .vga_on_in(vga_on_in),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .vga_rgb(vga_rgb), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_on(vga_on),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM, preloaded with data = address on its first edge.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < (1<<AW); i++) sram[i] <= DW'(i);
      loaded <= 1'b1;
    end else if (mem_we) begin
      sram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= sram[mem_addr];
  end

  typedef struct {
    logic          on, hs, vs, rv, fs;
    logic [DW-1:0] rgb, rd;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t idle_entry();
    exp_t e;
    e.on = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.rv = 1'b0; e.fs = 1'b0;
    e.rgb = '0; e.rd = '0;
    return e;
  endfunction

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  exp_t          q[$];
  exp_t          e, n;
  logic          rq_valid, rq_we;
  logic [AW-1:0] rq_addr;
  logic [DW-1:0] rq_wdata;
  logic          rst_now, on_now, xfer, resync;
  int            base, addr_exp;

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = DW'(i);
    reset = 1'b1; vga_hc = '0; vga_vc = '0; vga_on_in = 1'b0;
    vga_hsync_in = 1'b1; vga_vsync_in = 1'b1;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    rq_valid = 1'b0; rq_we = 1'b0; rq_addr = '0; rq_wdata = '0;
    resync = 1'b0; base = 0;
    q.push_back(idle_entry());
    q.push_back(idle_entry());

    for (int f = 0; f < 5; f++)
      for (int v = 0; v < V_TOT; v++)
        for (int h = 0; h < H_TOT; h++) begin
          @(negedge clk);
          rst_now = (f == 0 && v == 0 && h < 3) ||
                    (f == 1 && v == 5 && h >= H_DISP + 1 && h < H_DISP + 4) ||
                    (f == 2 && v == 3 && h >= 10 && h < 12);
          on_now = (h < H_DISP) && (v < V_DISP);
          if (!rq_valid) begin
            if (f == 1 && v == 5 && h == H_DISP - 2) begin
              rq_valid = 1'b1; rq_we = 1'b0; rq_addr = AW'(7); rq_wdata = '0;
            end else if ($urandom_range(0, 2) == 0) begin
              rq_valid = 1'b1;
              rq_we    = 1'($urandom_range(0, 1));
              rq_addr  = AW'($urandom_range(0, H_DISP * V_DISP - 1));
              rq_wdata = DW'($urandom);
            end
          end
          reset        = rst_now;
          vga_hc       = 10'(h);
          vga_vc       = 10'(v);
          vga_on_in    = on_now;
          vga_hsync_in = !(h >= H_DISP + 2 && h < H_DISP + 6);
          vga_vsync_in = !(v >= V_DISP + 1 && v < V_DISP + 3);
          host_valid   = rq_valid;
          host_we      = rq_we;
          host_addr    = rq_addr;
          host_wdata   = rq_wdata;
          #1;

          if (rst_now)
            for (int i = 0; i < q.size(); i++) q[i] = idle_entry();
          e = q.pop_front();
          check("vga_on", vga_on, e.on);
          check("vga_hsync", vga_hsync, e.hs);
          check("vga_vsync", vga_vsync, e.vs);
          check("vga_rgb", vga_rgb, e.rgb);
          check("frame_start", frame_start, e.fs);
          check("host_rvalid", host_rvalid, e.rv);
          if (e.rv) check("host_rdata", host_rdata, e.rd);

          xfer = rq_valid && !on_now && !rst_now;
          check("host_ready", host_ready, !on_now && !rst_now);

          // Pixel address is the raster index, re-based after a reset lands inside a frame.
          if (rst_now) resync = 1'b1;
          if (v >= V_DISP) begin resync = 1'b0; base = 0; end
          if (on_now && !rst_now && resync) begin base = v * H_DISP + h; resync = 1'b0; end
          addr_exp = v * H_DISP + h - base;

          if (on_now && !rst_now) begin
            check("disp_addr", mem_addr, addr_exp);
            check("disp_we", mem_we, 1'b0);
          end else if (xfer) begin
            check("host_addr", mem_addr, rq_addr);
            check("host_we", mem_we, rq_we);
            check("host_wdata", mem_wdata, rq_wdata);
          end else begin
            check("idle_we", mem_we, 1'b0);
            check("idle_wdata", mem_wdata, '0);
          end

          if (rst_now) begin
            n = idle_entry();
          end else begin
            n.on  = on_now;
            n.hs  = vga_hsync_in;
            n.vs  = vga_vsync_in;
            n.rgb = on_now ? ref_mem[addr_exp] : '0;
            n.rv  = xfer && !rq_we;
            n.rd  = ref_mem[rq_addr];
            n.fs  = on_now && h == 0 && v == 0;
          end
          q.push_back(n);

          if (xfer && rq_we) ref_mem[rq_addr] = rq_wdata;
          if (xfer) rq_valid = 1'b0;
        end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
